// File: rtl/fib_producer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fib_producer_pkg
//  Description : Shared definitions for the Fibonacci producer slice:
//                default data/count widths and the producer state encoding.
//                The default width is the one shared with the clock-crossing
//                buffer and the consumer on the other side.
//  Revision    : 1.0  initial release
// ============================================================================
package fib_producer_pkg;

    // Default data width of the clk_1 write side of the buffer.
    localparam int c_default_width = 16;

    // Wide enough to count every term that fits in c_default_width bits (25).
    localparam int c_default_cnt_w = 6;

    // Two-bit producer state. ST_RSVD is never entered; if it is ever seen
    // the FSM falls back to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_RSVD = 2'd3
    } state_t;

endpackage : fib_producer_pkg
`default_nettype wire

// File: rtl/fib_producer_if.sv
`default_nettype none
// ============================================================================
//  Module      : fib_producer_if
//  Description : Control and write-side bundle of the Fibonacci producer.
//                master : the producer (drives data_1/data_1_en and status)
//                slave  : the controller/buffer side (drives start, abort,
//                         buffer_full)
//  Signals     : start, abort, buffer_full          slave  -> master
//                data_1[WIDTH], data_1_en, busy,
//                done, term_count[CNT_W]            master -> slave
//  Revision    : 1.0  initial release
// ============================================================================
interface fib_producer_if #(
    parameter int WIDTH = fib_producer_pkg::c_default_width,
    parameter int CNT_W = fib_producer_pkg::c_default_cnt_w
) ();

    logic             start;
    logic             abort;
    logic             buffer_full;
    logic [WIDTH-1:0] data_1;
    logic             data_1_en;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] term_count;

    modport master (
        input  start,
        input  abort,
        input  buffer_full,
        output data_1,
        output data_1_en,
        output busy,
        output done,
        output term_count
    );

    modport slave (
        output start,
        output abort,
        output buffer_full,
        input  data_1,
        input  data_1_en,
        input  busy,
        input  done,
        input  term_count
    );

endinterface : fib_producer_if
`default_nettype wire

// File: rtl/fib_step.sv
`default_nettype none
// ============================================================================
//  Module      : fib_step
//  Description : Combinational Fibonacci datapath step. Adds the two current
//                terms at WIDTH+1 bits; the carry reports that the sum no
//                longer fits in WIDTH bits.
//  Ports       : a, b   [WIDTH]  in   current pair of terms
//                sum    [WIDTH]  out  low WIDTH bits of a+b
//                carry  [1]      out  bit WIDTH of a+b
//  Revision    : 1.0  initial release
// ============================================================================
module fib_step #(
    parameter int WIDTH = fib_producer_pkg::c_default_width
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    always_comb begin
        {carry, sum} = {1'b0, a} + {1'b0, b};
    end

endmodule : fib_step
`default_nettype wire

// File: rtl/fib_producer.sv
`default_nettype none
// ============================================================================
//  Module      : fib_producer
//  Description : Fibonacci source for the clk_1 write side of the clock-
//                crossing buffer. Emits F(0), F(1), ... as one-cycle
//                data_1/data_1_en pulses, stalls while buffer_full is high
//                and stops after the largest term below 2**WIDTH.
//  Ports       : clk_1            in   producer clock
//                rst              in   asynchronous active-high reset
//                bus (master)     start/abort/buffer_full in,
//                                 data_1/data_1_en/busy/done/term_count out
//  Revision    : 1.0  initial release
// ============================================================================
module fib_producer
    import fib_producer_pkg::*;
#(
    parameter int WIDTH = c_default_width,
    parameter int CNT_W = c_default_cnt_w
) (
    input  logic          clk_1,
    input  logic          rst,
    fib_producer_if.master bus
);

    // ------------------------------------------------------------------
    // State and datapath registers
    //  r_a     : next term to emit
    //  r_b     : the term after r_a (only meaningful while r_b_ok is set)
    //  r_b_ok  : r_b still fits in WIDTH bits; once clear, r_a is the last term
    // ------------------------------------------------------------------
    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_b_ok;
    logic [WIDTH-1:0] r_data;
    logic             r_data_en;
    logic             r_done;
    logic [CNT_W-1:0] r_cnt;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_a_nxt;
    logic [WIDTH-1:0] w_b_nxt;
    logic             w_b_ok_nxt;
    logic [WIDTH-1:0] w_data_nxt;
    logic             w_data_en_nxt;
    logic             w_done_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic [WIDTH-1:0] w_sum;
    logic             w_carry;

    fib_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .a     (r_a),
        .b     (r_b),
        .sum   (w_sum),
        .carry (w_carry)
    );

    // ------------------------------------------------------------------
    // Next-state and datapath decisions
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_a_nxt       = r_a;
        w_b_nxt       = r_b;
        w_b_ok_nxt    = r_b_ok;
        w_data_nxt    = r_data;
        w_data_en_nxt = 1'b0;
        w_done_nxt    = r_done;
        w_cnt_nxt     = r_cnt;

        if (bus.abort) begin
            // Abort beats start; data_1 and term_count keep their values
            // so the last emitted term stays observable.
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        w_state_nxt = ST_RUN;
                        w_a_nxt     = '0;
                        w_b_nxt     = {{(WIDTH-1){1'b0}}, 1'b1};
                        w_b_ok_nxt  = 1'b1;
                        w_cnt_nxt   = '0;
                        w_done_nxt  = 1'b0;
                    end
                end
                ST_RUN: begin
                    // A full buffer simply freezes the datapath, so a
                    // stall of any length loses or repeats nothing.
                    if (!bus.buffer_full) begin
                        w_data_nxt    = r_a;
                        w_data_en_nxt = 1'b1;
                        w_cnt_nxt     = r_cnt + CNT_W'(1);
                        w_a_nxt       = r_b;
                        w_b_nxt       = w_sum;
                        w_b_ok_nxt    = r_b_ok & ~w_carry;
                        // r_b overflowed earlier, so r_a is the final term.
                        if (!r_b_ok) begin
                            w_state_nxt = ST_DONE;
                            w_done_nxt  = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_1 or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_a       <= '0;
            r_b       <= {{(WIDTH-1){1'b0}}, 1'b1};
            r_b_ok    <= 1'b1;
            r_data    <= '0;
            r_data_en <= 1'b0;
            r_done    <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_a       <= w_a_nxt;
            r_b       <= w_b_nxt;
            r_b_ok    <= w_b_ok_nxt;
            r_data    <= w_data_nxt;
            r_data_en <= w_data_en_nxt;
            r_done    <= w_done_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    assign bus.data_1     = r_data;
    assign bus.data_1_en  = r_data_en;
    assign bus.busy       = (r_state == ST_RUN);
    assign bus.done       = r_done;
    assign bus.term_count = r_cnt;

endmodule : fib_producer
`default_nettype wire

// File: tb/tb_fib_producer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fib_producer
//  Description : Self-checking bench for fib_producer. A transaction-level
//                model (precomputed term list plus running/done flags)
//                predicts every strobe, term and status output.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fib_producer;

    localparam int WIDTH = 16;
    localparam int CNT_W = 6;

    logic clk_1 = 1'b0;
    logic rst   = 1'b1;

    fib_producer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    fib_producer #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk_1 (clk_1),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 clk_1 = ~clk_1;

    // Reference: every Fibonacci term below 2**WIDTH, in order.
    int seq[$];

    // Model state
    bit m_running;
    bit m_done;
    bit m_en;
    int m_data;
    int m_idx;
    int m_cnt;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void build_seq();
        longint x = 0;
        longint y = 1;
        longint t;
        seq.delete();
        while (x < (longint'(1) << WIDTH)) begin
            seq.push_back(int'(x));
            t = x + y;
            x = y;
            y = t;
        end
    endfunction

    function automatic void model_reset();
        m_running = 0;
        m_done    = 0;
        m_en      = 0;
        m_data    = 0;
        m_idx     = 0;
        m_cnt     = 0;
    endfunction

    // One clock edge of the producer, described in terms of transactions.
    function automatic void model_edge();
        m_en = 0;
        if (rst) begin
            model_reset();
        end else if (bus.abort) begin
            m_running = 0;
            m_done    = 0;
        end else if (m_running) begin
            if (!bus.buffer_full) begin
                m_en   = 1;
                m_data = seq[m_idx];
                m_idx++;
                m_cnt++;
                if (m_idx == seq.size()) begin
                    m_running = 0;
                    m_done    = 1;
                end
            end
        end else if (bus.start) begin
            m_running = 1;
            m_done    = 0;
            m_idx     = 0;
            m_cnt     = 0;
        end
    endfunction

    task automatic compare();
        chk("data_1_en",  bus.data_1_en,  m_en);
        chk("data_1",     bus.data_1,     m_data);
        chk("busy",       bus.busy,       m_running);
        chk("done",       bus.done,       m_done);
        chk("term_count", bus.term_count, m_cnt);
    endtask

    // Inputs change at the falling edge only, so they are stable at posedge.
    task automatic step();
        @(posedge clk_1);
        model_edge();
        @(negedge clk_1);
        compare();
    endtask

    task automatic run_to_done(input int limit);
        int k = 0;
        while (!m_done && k < limit) begin
            step();
            k++;
        end
        if (!m_done) chk("timeout_done", 0, 1);
    endtask

    task automatic wait_emit(input int val, input int limit);
        int k = 0;
        bit seen = 0;
        while (!seen && k < limit) begin
            step();
            seen = m_en && (m_data == val);
            k++;
        end
        if (!seen) chk("timeout_emit", 0, 1);
    endtask

    task automatic kick();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    initial begin
        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        bus.buffer_full = 1'b0;
        build_seq();
        model_reset();

        // Reset state
        repeat (2) @(negedge clk_1);
        compare();
        rst = 1'b0;

        // 1: full uninterrupted run
        kick();
        run_to_done(60);
        chk("final_count", bus.term_count, seq.size());
        chk("final_term",  bus.data_1,     seq[seq.size()-1]);

        // 2: three-edge stall right after the strobe of 5
        kick();
        wait_emit(5, 20);
        bus.buffer_full = 1'b1;
        repeat (3) step();
        bus.buffer_full = 1'b0;
        step();
        chk("after_stall", bus.data_1, 8);
        run_to_done(60);

        // 3: abort after 13, then restart from 0
        kick();
        wait_emit(13, 20);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("abort_busy", bus.busy, 0);
        kick();
        step();
        chk("restart_first", bus.data_1, 0);
        run_to_done(60);

        // 4: start held through the whole run, then restart from DONE
        bus.start = 1'b1;
        step();
        run_to_done(60);
        step();
        bus.start = 1'b0;
        step();
        chk("done_restart_en", bus.data_1_en, 1);

        // 5: abort and start together in IDLE
        bus.abort = 1'b1;
        step();
        bus.start = 1'b1;
        step();
        bus.abort = 1'b0;
        bus.start = 1'b0;
        repeat (2) step();
        chk("abort_start_busy", bus.busy, 0);

        // 6: asynchronous reset between edges mid-run
        kick();
        wait_emit(8, 20);
        @(posedge clk_1);
        model_edge();
        #2 rst = 1'b1;
        #1;
        chk("arst_data",  bus.data_1,     0);
        chk("arst_en",    bus.data_1_en,  0);
        chk("arst_busy",  bus.busy,       0);
        chk("arst_count", bus.term_count, 0);
        model_reset();
        @(negedge clk_1);
        rst = 1'b0;
        compare();
        kick();
        run_to_done(60);

        // Randomized traffic: back-pressure, starts and occasional aborts
        for (int i = 0; i < 600; i++) begin
            bus.buffer_full = ($urandom_range(0, 3) == 0);
            bus.start       = ($urandom_range(0, 7) == 0);
            bus.abort       = ($urandom_range(0, 59) == 0);
            step();
        end
        bus.buffer_full = 1'b0;
        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_fib_producer
`default_nettype wire
